// File: rtl/alu32.sv
// alu32: registered 32-bit, 8-function ALU (logic, add with carry, logical shifts, truncate)
module alu32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             CI,
  input  logic [2:0]       A,
  output logic [WIDTH-1:0] FinalOut,
  output logic             CO
);
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result_d, result_q;
  logic             co_d, co_q;
  always_comb begin
    sum = {1'b0, In1} + {1'b0, In2} + {{WIDTH{1'b0}}, CI};
    result_d = '0;
    case (A)
      3'b000:  result_d = In1 & In2;
      3'b001:  result_d = In1 | In2;
      3'b010:  result_d = In1 ^ In2;
      3'b011:  result_d = ~In1;
      3'b100:  result_d = sum[WIDTH-1:0];
      3'b101:  result_d = In1 << In2[4:0];
      3'b110:  result_d = In1 >> In2[4:0];
      default: result_d = {{(WIDTH/2){1'b0}}, In1[WIDTH/2-1:0]};
    endcase
    co_d = (A == 3'b100) ? sum[WIDTH] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      co_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      co_q     <= co_d;
    end
  end
  assign FinalOut = result_q;
  assign CO       = co_q;
endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed and random self-checking bench for alu32
module tb_alu32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] In1, In2;
  logic        CI;
  logic [2:0]  A;
  logic [31:0] FinalOut;
  logic        CO;
  int checks = 0;
  int errors = 0;
  alu32 dut (
    .clk(clk), .rst_n(rst_n), .In1(In1), .In2(In2), .CI(CI), .A(A),
    .FinalOut(FinalOut), .CO(CO)
  );
  always #5 clk = ~clk;
  task automatic apply(input logic [31:0] i1, input logic [31:0] i2, input logic c, input logic [2:0] op);
    In1 = i1;
    In2 = i2;
    CI  = c;
    A   = op;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] er, input logic ec);
    checks++;
    assert (FinalOut === er) else begin
      errors++;
      $error("FAIL %s FinalOut got %h want %h", tag, FinalOut, er);
    end
    checks++;
    assert (CO === ec) else begin
      errors++;
      $error("FAIL %s CO got %b want %b", tag, CO, ec);
    end
  endtask
  function automatic logic [32:0] model(input logic [31:0] i1, input logic [31:0] i2, input logic c, input logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    int n;
    n = int'(i2[4:0]);
    r = 32'h0;
    case (op)
      3'd0: r = i1 & i2;
      3'd1: r = i1 | i2;
      3'd2: r = i1 ^ i2;
      3'd3: r = ~i1;
      3'd4: begin
        s = {1'b0, i1} + {1'b0, i2} + {32'h0, c};
        return s;
      end
      3'd5: for (int k = 0; k < 32; k++) r[k] = (k >= n) ? i1[k-n] : 1'b0;
      3'd6: for (int k = 0; k < 32; k++) r[k] = (k + n < 32) ? i1[k+n] : 1'b0;
      default: r = {16'h0000, i1[15:0]};
    endcase
    return {1'b0, r};
  endfunction
  initial begin
    logic [32:0] exp_v;
    logic [31:0] r1, r2;
    logic        rc;
    rst_n = 1'b0;
    apply(32'hFFFFFFFF, 32'h0, 1'b0, 3'b011);
    check("reset1", 32'h0, 1'b0);
    apply(32'hFFFFFFFF, 32'h0, 1'b0, 3'b011);
    check("reset2", 32'h0, 1'b0);
    rst_n = 1'b1;
    apply(32'hFFFFFFFF, 32'h0, 1'b0, 3'b011);
    check("not_after_reset", 32'h0, 1'b0);
    apply(32'hF0F0A5A5, 32'h0FF0FFFF, 1'b1, 3'b000);
    check("and", 32'h00F0A5A5, 1'b0);
    apply(32'hF0F0A5A5, 32'h0FF0FFFF, 1'b1, 3'b001);
    check("or", 32'hFFF0FFFF, 1'b0);
    apply(32'hF0F0A5A5, 32'h0FF0FFFF, 1'b1, 3'b010);
    check("xor", 32'hFF005A5A, 1'b0);
    apply(32'hF0F0A5A5, 32'h0FF0FFFF, 1'b1, 3'b011);
    check("not", 32'h0F0F5A5A, 1'b0);
    apply(32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b100);
    check("add_wrap", 32'h00000000, 1'b1);
    apply(32'h00000000, 32'h00000000, 1'b0, 3'b000);
    check("co_cleared", 32'h00000000, 1'b0);
    apply(32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b100);
    check("add_wrap2", 32'h00000000, 1'b1);
    rst_n = 1'b0;
    apply(32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100);
    check("reset_midstream", 32'h0, 1'b0);
    rst_n = 1'b1;
    apply(32'h12345678, 32'h11111111, 1'b0, 3'b100);
    check("add_plain", 32'h23456789, 1'b0);
    apply(32'h12345678, 32'h11111111, 1'b1, 3'b100);
    check("add_ci", 32'h2345678A, 1'b0);
    apply(32'h80000001, 32'h00000024, 1'b1, 3'b101);
    check("lshift4", 32'h00000010, 1'b0);
    apply(32'h80000001, 32'h00000024, 1'b1, 3'b110);
    check("rshift4", 32'h08000000, 1'b0);
    apply(32'h80000001, 32'hFFFFFFE0, 1'b1, 3'b101);
    check("lshift0", 32'h80000001, 1'b0);
    apply(32'h80000001, 32'hFFFFFFE0, 1'b1, 3'b110);
    check("rshift0", 32'h80000001, 1'b0);
    apply(32'hFFFFFFFF, 32'h0000001F, 1'b0, 3'b101);
    check("lshift31", 32'h80000000, 1'b0);
    apply(32'hFFFFFFFF, 32'h0000001F, 1'b0, 3'b110);
    check("rshift31", 32'h00000001, 1'b0);
    apply(32'hDEADBEEF, 32'h12345678, 1'b1, 3'b111);
    check("truncate", 32'h0000BEEF, 1'b0);
    apply(32'h7FFFFFFF, 32'h00000001, 1'b0, 3'b100);
    check("add_b2b", 32'h80000000, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      for (int op = 0; op < 8; op++) begin
        r1 = $urandom;
        r2 = $urandom;
        rc = 1'($urandom_range(0, 1));
        exp_v = model(r1, r2, rc, 3'(op));
        apply(r1, r2, rc, 3'(op));
        check("random", exp_v[31:0], exp_v[32]);
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
